// File: rtl/synth_pkg.sv
// Shared note-event types and scheduler defaults for the synthesizer note path.
// NOTE_SCHED_VEL_EN: when defined, note events carry an 8-bit velocity field.
package synth_pkg;

    localparam int unsigned DEF_DEPTH    = 4;
    localparam int unsigned DEF_NOTE_DLY = 2;

    // Address field is sized for the widest supported voice address; narrower
    // configurations leave the upper bits constant zero.
    localparam int unsigned EVT_ADR_W    = 8;
    localparam int unsigned KEY_W        = 8;
    localparam int unsigned VEL_W        = 8;

    typedef struct packed {
        logic [EVT_ADR_W-1:0] adr;
        logic [KEY_W-1:0]     key;
`ifdef NOTE_SCHED_VEL_EN
        logic [VEL_W-1:0]     vel;
`endif
    } note_evt_t;

endpackage

// File: rtl/note_evt_fifo.sv
// Synchronous circular FIFO of note events; pointers carry one extra wrap bit
// so full and empty are told apart without a separate flag.
module note_evt_fifo
    import synth_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                         OSC_CLK,
    input  logic                         iRST_N,
    input  logic                         push,
    input  note_evt_t                    wr_data,
    input  logic                         pop,
    output note_evt_t                    rd_data_c,
    output logic                         full_c,
    output logic                         empty_c,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    note_evt_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_ok_c;
    logic              pop_ok_c;

    assign empty_c   = (wr_ptr == rd_ptr);
    assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok_c  = pop && !empty_c;
    // A pop in the same cycle frees the slot the push would otherwise lack.
    assign push_ok_c = push && (!full_c || pop_ok_c);
    assign rd_data_c = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge OSC_CLK) begin
        if (!iRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge OSC_CLK) begin
        if (push_ok_c) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/note_event_scheduler.sv
// Frame-aligned note-on scheduler: queues decoder events and releases at most
// one per voice-scan frame. NOTE_SCHED_VEL_EN enables velocity storage.
module note_event_scheduler
    import synth_pkg::*;
#(
    parameter int unsigned VOICES   = 8,
    parameter int unsigned V_WIDTH  = 3,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NOTE_DLY = DEF_NOTE_DLY
) (
    input  logic                         OSC_CLK,
    input  logic                         iRST_N,
    input  logic                         n_xxxx_zero,
    input  logic                         note_on,
    input  logic [V_WIDTH-1:0]           cur_key_adr,
    input  logic [KEY_W-1:0]             cur_key_val,
    input  logic [VEL_W-1:0]             cur_vel_on,
    input  logic [VOICES-1:0]            keys_on,
    input  logic                         clr_ovf,
    output logic                         o_note_on,
    output logic [V_WIDTH-1:0]           o_key_adr,
    output logic [KEY_W-1:0]             o_key_val,
    output logic [VEL_W-1:0]             o_vel,
    output logic [VOICES-1:0]            o_keys_on,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         overflow
);

    logic                nz_prev;
    logic                fs_c;
    logic                pop_c;
    logic                drop_c;
    logic                full_c;
    logic                empty_c;
    note_evt_t           wr_evt_c;
    note_evt_t           head_c;
    logic [NOTE_DLY-1:0] pulse_sr;

    // Frame start: falling edge of the frame marker, one cycle wide.
    assign fs_c   = nz_prev & ~n_xxxx_zero;
    assign pop_c  = fs_c & ~empty_c;
    assign drop_c = note_on & full_c & ~pop_c;

    always_comb begin
        wr_evt_c     = '0;
        wr_evt_c.adr = EVT_ADR_W'(cur_key_adr);
        wr_evt_c.key = cur_key_val;
`ifdef NOTE_SCHED_VEL_EN
        wr_evt_c.vel = cur_vel_on;
`endif
    end

    note_evt_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .OSC_CLK   (OSC_CLK),
        .iRST_N    (iRST_N),
        .push      (note_on),
        .wr_data   (wr_evt_c),
        .pop       (pop_c),
        .rd_data_c (head_c),
        .full_c    (full_c),
        .empty_c   (empty_c),
        .level     (fifo_level)
    );

    // Reset rearms the detector so a low marker at release counts as a frame start.
    always_ff @(posedge OSC_CLK) begin
        if (!iRST_N) begin
            nz_prev <= 1'b1;
        end else begin
            nz_prev <= n_xxxx_zero;
        end
    end

    always_ff @(posedge OSC_CLK) begin
        if (!iRST_N) begin
            o_key_adr <= '0;
            o_key_val <= '0;
            o_keys_on <= '0;
            pulse_sr  <= '0;
            overflow  <= 1'b0;
        end else begin
            pulse_sr <= (pulse_sr << 1) | NOTE_DLY'(pop_c);
            if (pop_c) begin
                o_key_adr <= head_c.adr[V_WIDTH-1:0];
                o_key_val <= head_c.key;
            end
            if (fs_c) begin
                o_keys_on <= keys_on;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign o_note_on = pulse_sr[NOTE_DLY-1];

`ifdef NOTE_SCHED_VEL_EN
    always_ff @(posedge OSC_CLK) begin
        if (!iRST_N) begin
            o_vel <= '0;
        end else if (pop_c) begin
            o_vel <= head_c.vel;
        end
    end
`else
    logic vel_unused_c;
    assign vel_unused_c = ^cur_vel_on;
    assign o_vel        = 8'd0;
`endif

    // Upper address bits of stored events are constant zero when V_WIDTH is narrow.
    if (V_WIDTH < EVT_ADR_W) begin : g_adr_pad
        logic adr_pad_unused_c;
        assign adr_pad_unused_c = ^head_c.adr[EVT_ADR_W-1:V_WIDTH];
    end

endmodule

// File: tb/tb_note_event_scheduler.sv
// Scoreboard bench for note_event_scheduler: a transaction model predicts
// released events, their pulse cycle and the registered outputs.
module tb_note_event_scheduler;

    localparam int unsigned VOICES   = 8;
    localparam int unsigned V_WIDTH  = 3;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned NOTE_DLY = 2;
    localparam int unsigned LW       = $clog2(DEPTH + 1);
`ifdef NOTE_SCHED_VEL_EN
    localparam bit VEL_EN = 1'b1;
`else
    localparam bit VEL_EN = 1'b0;
`endif

    logic                OSC_CLK = 1'b0;
    logic                iRST_N;
    logic                n_xxxx_zero;
    logic                note_on;
    logic [V_WIDTH-1:0]  cur_key_adr;
    logic [7:0]          cur_key_val;
    logic [7:0]          cur_vel_on;
    logic [VOICES-1:0]   keys_on;
    logic                clr_ovf;
    logic                o_note_on;
    logic [V_WIDTH-1:0]  o_key_adr;
    logic [7:0]          o_key_val;
    logic [7:0]          o_vel;
    logic [VOICES-1:0]   o_keys_on;
    logic [LW-1:0]       fifo_level;
    logic                overflow;

    typedef struct {
        logic [V_WIDTH-1:0] adr;
        logic [7:0]         key;
        logic [7:0]         vel;
        int                 due;
    } sb_evt_t;

    sb_evt_t             m_q[$];
    sb_evt_t             exp_q[$];
    bit                  m_prev;
    logic [V_WIDTH-1:0]  m_adr;
    logic [7:0]          m_key;
    logic [7:0]          m_vel;
    logic [VOICES-1:0]   m_keys;
    bit                  m_ovf;
    int                  cyc = 0;
    int                  n_checks = 0;
    int                  n_errors = 0;
    bit                  chk_en = 1'b0;

    note_event_scheduler #(
        .VOICES      (VOICES),
        .V_WIDTH     (V_WIDTH),
        .DEPTH       (DEPTH),
        .NOTE_DLY    (NOTE_DLY)
    ) dut (
        .OSC_CLK     (OSC_CLK),
        .iRST_N      (iRST_N),
        .n_xxxx_zero (n_xxxx_zero),
        .note_on     (note_on),
        .cur_key_adr (cur_key_adr),
        .cur_key_val (cur_key_val),
        .cur_vel_on  (cur_vel_on),
        .keys_on     (keys_on),
        .clr_ovf     (clr_ovf),
        .o_note_on   (o_note_on),
        .o_key_adr   (o_key_adr),
        .o_key_val   (o_key_val),
        .o_vel       (o_vel),
        .o_keys_on   (o_keys_on),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 OSC_CLK = ~OSC_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: evaluates each rising edge with the inputs the DUT sees.
    initial begin
        sb_evt_t e;
        bit      fs;
        bit      drop;
        forever begin
            @(posedge OSC_CLK);
            if (!iRST_N) begin
                m_q.delete();
                exp_q.delete();
                m_prev = 1'b1;
                m_adr  = '0;
                m_key  = '0;
                m_vel  = '0;
                m_keys = '0;
                m_ovf  = 1'b0;
            end else begin
                fs     = m_prev && !n_xxxx_zero;
                m_prev = n_xxxx_zero;
                if (fs && m_q.size() != 0) begin
                    e     = m_q.pop_front();
                    e.due = cyc + NOTE_DLY;
                    m_adr = e.adr;
                    m_key = e.key;
                    m_vel = e.vel;
                    exp_q.push_back(e);
                end
                if (fs) begin
                    m_keys = keys_on;
                end
                drop = note_on && (m_q.size() >= DEPTH);
                if (note_on && !drop) begin
                    e.adr = cur_key_adr;
                    e.key = cur_key_val;
                    e.vel = VEL_EN ? cur_vel_on : 8'd0;
                    e.due = 0;
                    m_q.push_back(e);
                end
                if (drop) begin
                    m_ovf = 1'b1;
                end else if (clr_ovf) begin
                    m_ovf = 1'b0;
                end
            end
            cyc++;
        end
    end

    // Output side of the scoreboard, sampled mid-cycle.
    initial begin
        sb_evt_t e;
        forever begin
            @(negedge OSC_CLK);
            if (chk_en) begin
                if (o_note_on) begin
                    if (exp_q.size() == 0) begin
                        check("pulse_spurious", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_cycle", cyc, e.due);
                        check("pulse_adr", o_key_adr, e.adr);
                        check("pulse_key", o_key_val, e.key);
                        check("pulse_vel", o_vel, e.vel);
                    end
                end
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    check("pulse_missed", 0, 1);
                    void'(exp_q.pop_front());
                end
                check("adr_reg", o_key_adr, m_adr);
                check("key_reg", o_key_val, m_key);
                check("vel_reg", o_vel, m_vel);
                check("keys_snap", o_keys_on, m_keys);
                check("level", fifo_level, m_q.size());
                check("overflow", overflow, m_ovf);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge OSC_CLK);
            #1;
        end
    endtask

    task automatic push_evt(input int adr, input int key, input int vel);
        note_on     = 1'b1;
        cur_key_adr = V_WIDTH'(adr);
        cur_key_val = 8'(key);
        cur_vel_on  = 8'(vel);
        tick(1);
        note_on     = 1'b0;
    endtask

    // Drops the marker for one cycle; returns in cycle F+1.
    task automatic frame_start();
        n_xxxx_zero = 1'b0;
        tick(1);
        n_xxxx_zero = 1'b1;
    endtask

    initial begin
        int len;
        iRST_N      = 1'b0;
        n_xxxx_zero = 1'b1;
        note_on     = 1'b0;
        cur_key_adr = '0;
        cur_key_val = '0;
        cur_vel_on  = '0;
        keys_on     = '0;
        clr_ovf     = 1'b0;
        tick(2);
        chk_en = 1'b1;
        check("rst_pulse", o_note_on, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        iRST_N = 1'b1;
        tick(2);

        // Single event through one frame.
        push_evt(3, 60, 100);
        check("t1_level1", fifo_level, 1);
        tick(1);
        frame_start();
        check("t1_adr", o_key_adr, 3);
        check("t1_key", o_key_val, 60);
        check("t1_vel", o_vel, VEL_EN ? 100 : 0);
        check("t1_level0", fifo_level, 0);
        check("t1_no_early", o_note_on, 0);
        tick(1);
        check("t1_pulse", o_note_on, 1);
        tick(1);
        check("t1_pulse_end", o_note_on, 0);
        tick(2);

        // Overflow: five pushes into four slots, then set beats clear.
        for (int i = 0; i < 5; i++) begin
            push_evt(i + 1, 70 + i, 10 + i);
        end
        check("t2_level_full", fifo_level, 4);
        check("t2_ovf", overflow, 1);
        clr_ovf = 1'b1;
        push_evt(6, 75, 15);
        clr_ovf = 1'b0;
        check("t2_set_wins", overflow, 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("t2_clr", overflow, 0);

        // Full FIFO with push coincident with frame start.
        n_xxxx_zero = 1'b0;
        push_evt(7, 80, 20);
        n_xxxx_zero = 1'b1;
        check("t3_level", fifo_level, 4);
        check("t3_ovf", overflow, 0);
        check("t3_head", o_key_val, 70);
        tick(3);
        repeat (4) begin
            frame_start();
            tick(3);
        end
        check("t3_drained", fifo_level, 0);
        check("t3_last", o_key_val, 80);

        // Push during frame start on an empty FIFO: no bypass.
        n_xxxx_zero = 1'b0;
        push_evt(2, 90, 30);
        n_xxxx_zero = 1'b1;
        check("t4_level", fifo_level, 1);
        check("t4_hold_key", o_key_val, 80);
        tick(1);
        check("t4_no_pulse", o_note_on, 0);
        tick(2);
        frame_start();
        tick(1);
        check("t4_pulse", o_note_on, 1);
        check("t4_key", o_key_val, 90);
        tick(2);

        // Snapshot on an empty frame.
        keys_on = 8'hA5;
        frame_start();
        keys_on = '0;
        check("t5_keys", o_keys_on, 8'hA5);
        check("t5_np1", o_note_on, 0);
        tick(1);
        check("t5_np2", o_note_on, 0);
        check("t5_hold", o_key_val, 90);
        tick(2);

        // Reset one cycle after a pop cancels the pulse and flushes everything.
        for (int i = 0; i < 5; i++) begin
            push_evt(4, 50 + i, 60 + i);
        end
        tick(1);
        frame_start();
        iRST_N = 1'b0;
        tick(1);
        check("t6_no_pulse", o_note_on, 0);
        check("t6_adr", o_key_adr, 0);
        check("t6_key", o_key_val, 0);
        check("t6_vel", o_vel, 0);
        check("t6_keys", o_keys_on, 0);
        check("t6_level", fifo_level, 0);
        check("t6_ovf", overflow, 0);
        keys_on     = 8'h3C;
        n_xxxx_zero = 1'b0;
        tick(1);
        iRST_N = 1'b1;
        tick(1);
        check("t6_rearm", o_keys_on, 8'h3C);
        n_xxxx_zero = 1'b1;
        keys_on     = '0;
        tick(3);

        // Random traffic against the model.
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(7, 3));
            for (int c = 0; c < len; c++) begin
                n_xxxx_zero = (c == 0) ? 1'b0 : 1'b1;
                note_on     = ($urandom_range(2, 0) == 0);
                cur_key_adr = V_WIDTH'($urandom);
                cur_key_val = 8'($urandom);
                cur_vel_on  = 8'($urandom);
                keys_on     = VOICES'($urandom);
                clr_ovf     = ($urandom_range(7, 0) == 0);
                tick(1);
            end
        end
        n_xxxx_zero = 1'b1;
        note_on     = 1'b0;
        clr_ovf     = 1'b0;
        tick(6);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/note_event_scheduler.md
# note_event_scheduler

Parametrised note-event front end for the synthesizer engine. It sits between the MIDI decoder outputs and the `pitch_control` / `env_gen_indexed` inputs.

- Queues incoming note-on events in a FIFO.
- Releases at most one event per voice-scan frame, aligned to the frame marker `n_xxxx_zero`.
- Snapshots `keys_on` once per frame.

It replaces the asynchronous negedge capture and fixed 2-stage `note_on` delay with a single-clock, fully synchronous scheduler. Queue depth, voice count and pulse delay are all parametrised, and lost events are reported as overflow.

## Interface
Parameters:
- `VOICES`, 8, number of voices; width of `keys_on`.
- `V_WIDTH`, 3, voice address width; `VOICES` ≤ 2^`V_WIDTH`.
- `DEPTH`, 4, event FIFO entries; ≥ 2, power of two.
- `NOTE_DLY`, 2, cycles from frame start to `o_note_on` pulse; 1..7.

Ports:
- `OSC_CLK`  in  1  sole clock; all logic on rising edge.
- `iRST_N`  in  1  synchronous, active-low reset.
- `n_xxxx_zero`  in  1  frame marker; low while voice-scan index is zero.
- `note_on`  in  1  one-cycle strobe; push event.
- `cur_key_adr`  in  `V_WIDTH`  target voice of event.
- `cur_key_val`  in  8  MIDI key number.
- `cur_vel_on`  in  8  note-on velocity.
- `keys_on`  in  `VOICES`  live key-held mask.
- `clr_ovf`  in  1  clears `overflow`.
- `o_note_on`  out  1  one-cycle pulse per released event.
- `o_key_adr`  out  `V_WIDTH`  voice of last released event.
- `o_key_val`  out  8  key of last released event.
- `o_vel`  out  8  velocity of last released event.
- `o_keys_on`  out  `VOICES`  `keys_on` snapshot taken at frame start.
- `fifo_level`  out  `$clog2(DEPTH+1)`  entries queued.
- `overflow`  out  1  sticky; an event was dropped.

## Operation
- Frame start (FS) is one cycle wide. It is detected when the registered previous `n_xxxx_zero` is 1 and the current value is 0. The previous-value register resets to 1.
- Push: `note_on`=1 writes {`cur_key_adr`, `cur_key_val`, `cur_vel_on`} to the FIFO tail.
- Pop: on FS, if the FIFO is non-empty, the head is popped. At most one pop per frame.
- There is no bypass. An event pushed in the same cycle as FS is never released in that FS. It waits at least until the next FS.
- Full and push without pop: the event is dropped, `overflow` is set, and `fifo_level` is unchanged.
- Full and push with simultaneous pop: pop first, then push is accepted. `fifo_level` stays at `DEPTH` and there is no overflow.
- Empty and FS: no pop, no pulse, and output data holds its previous value.
- `overflow` clears when `clr_ovf`=1. If `clr_ovf` and a new drop occur in the same cycle, the set wins.
- FIFO pointers carry one extra bit, so full and empty are distinguished by pointer MSB comparison. Pointers wrap modulo 2·`DEPTH`.
- Pulse pipeline: a `NOTE_DLY`-bit shift register is loaded on pop. A new pop cannot occur before the previous pulse has emerged, because `NOTE_DLY` is less than the frame length.

## Timing
- Pop at FS cycle F:
  - `o_key_adr`, `o_key_val`, `o_vel` update at F+1.
  - `o_note_on` is high in cycle F+`NOTE_DLY` only.
- `o_keys_on` updates at F+1 on every FS, whether or not the FIFO is empty.
- `fifo_level` updates the cycle after a push or pop.
- Reset (`iRST_N`=0 on a clock edge), including mid-frame or mid-pulse:
  - FIFO is flushed and pending pulses are cancelled.
  - All outputs read 0 from the next cycle (`o_note_on`, `o_key_adr`, `o_key_val`, `o_vel`, `o_keys_on`, `fifo_level`, `overflow`).
  - The FS detector is rearmed (previous value = 1). If `n_xxxx_zero` is low when reset releases, that counts as an FS.

## Configuration
- `NOTE_SCHED_VEL_EN` defined: velocity is stored in the FIFO and `o_vel` carries the popped `cur_vel_on`.
- Undefined: FIFO entries omit velocity (8 bits narrower per entry), `o_vel` is tied to 8'd0, and `cur_vel_on` is ignored.

## Structure
- `synth_pkg` holds:
  - `note_evt_t` struct {adr, key, vel}, with the vel field conditional on the macro.
  - The default `DEPTH` and `NOTE_DLY` constants.
- One sub-module, `note_evt_fifo`: synchronous circular FIFO with push, pop, full, empty and level. It has no knowledge of frames.
- Top-level logic: FS detector, pop control, output registers, pulse shifter, overflow flag.

## Test plan
Defaults `DEPTH`=4, `NOTE_DLY`=2, `VOICES`=8, `NOTE_SCHED_VEL_EN` defined.
- Single event {adr 3, key 60, vel 100}, then FS at cycle F -> outputs 3/60/100 at F+1, one `o_note_on` pulse at F+2, `fifo_level` 1→0.
- Push 5 events with no FS -> first 4 queued, `fifo_level`=4, `overflow`=1. Then 4 FS -> keys released in push order, one per frame.
- FIFO full, push coincident with FS -> head popped, new event accepted, `fifo_level` stays 4, `overflow` stays 0.
- `note_on` in the FS cycle on an empty FIFO -> no pulse in that frame; released at the next FS.
- `keys_on`=8'hA5 at FS with empty FIFO -> `o_keys_on`=8'hA5 at F+1, no `o_note_on`.
- Reset asserted at F+1 of a pop -> no `o_note_on` at F+2, all outputs 0, `fifo_level`=0.
